// File: rtl/axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_wr_arbiter
//
// Purpose:
//   Round-robin arbiter that grants one of four requesters ownership of a single
//   AXI-style write data / write response channel for one burst of DATA_LEN
//   beats. The owner's 32-bit data slice is muxed onto M_WDATA while the burst
//   is in progress; the burst closes when the slave returns BVALID.
//
// Parameters:
//   DATA_LEN   beats per burst (1..256)
//   BRESP_TMO  write-response timeout in cycles (2..65535), used only when the
//              timeout build option is enabled
//
// Build option:
//   AXI_WR_ARB_BRESP_TMO_EN  when defined, a 16-bit RESP-phase timer aborts a
//                            burst whose response never arrives and pulses err.
//                            When undefined, RESP waits forever and err is 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-requester burst request (level)
//   req_data   requester i beat data on [32i+31:32i]
//   grant      one-hot channel owner, 0 when idle
//   beat_ack   per-requester accepted-beat pulse (owner bit only)
//   done       per-requester burst-complete pulse (owner bit only)
//   err        per-requester response-timeout pulse (owner bit only)
//   M_WDATA    write data to slave
//   M_WVALID   write data valid
//   M_WLAST    last beat of burst
//   S_WREADY   slave ready for write data
//   BVALID     slave write response valid
//   BREADY     ready for write response
//
// States:
//   state | meaning
//   IDLE  | no owner; arbitrate among req each cycle
//   DATA  | owner streaming DATA_LEN beats to the slave
//   RESP  | all beats sent; waiting for BVALID (or timeout)
// -----------------------------------------------------------------------------
module axi_wr_arbiter #(
    parameter int DATA_LEN  = 256,
    parameter int BRESP_TMO = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] req_data,
    output logic [3:0]   grant,
    output logic [3:0]   beat_ack,
    output logic [3:0]   done,
    output logic [3:0]   err,
    output logic [31:0]  M_WDATA,
    output logic         M_WVALID,
    output logic         M_WLAST,
    input  logic         S_WREADY,
    input  logic         BVALID,
    output logic         BREADY
);

    // Elaboration-time guard on parameter ranges.
    if (DATA_LEN < 1 || DATA_LEN > 256) begin : g_bad_data_len
        $error("axi_wr_arbiter: DATA_LEN must be in 1..256");
    end
    if (BRESP_TMO < 2 || BRESP_TMO > 65535) begin : g_bad_bresp_tmo
        $error("axi_wr_arbiter: BRESP_TMO must be in 2..65535");
    end

    localparam logic [7:0] LP_LAST_CNT = 8'(DATA_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_grant;
    logic        r_wvalid;
    logic        r_bready;
    logic [7:0]  r_count;
    logic [1:0]  r_last;

    logic        w_found;
    logic [1:0]  w_winner_idx;
    logic [1:0]  w_try_idx;
    logic [1:0]  w_owner_idx;
    logic [31:0] w_owner_data;
    logic        w_xfer;
    logic        w_last_beat;
    logic        w_resp_ok;
    logic        w_resp_tmo;

    // Round-robin search: candidates in order last+1, last+2, last+3, last.
    // The 2-bit add wraps 3->0 naturally.
    always_comb begin
        w_found      = 1'b0;
        w_winner_idx = 2'd0;
        w_try_idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_try_idx = r_last + 2'(k);
            if (!w_found && req[w_try_idx]) begin
                w_found      = 1'b1;
                w_winner_idx = w_try_idx;
            end
        end
    end

    always_comb begin
        w_owner_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (r_grant[k]) begin
                w_owner_idx = 2'(k);
            end
        end
    end

    always_comb begin
        case (w_owner_idx)
            2'd0:    w_owner_data = req_data[31:0];
            2'd1:    w_owner_data = req_data[63:32];
            2'd2:    w_owner_data = req_data[95:64];
            default: w_owner_data = req_data[127:96];
        endcase
    end

    assign w_xfer      = r_wvalid & S_WREADY;
    assign w_last_beat = (r_state == ST_DATA) && (r_count == LP_LAST_CNT);
    assign w_resp_ok   = (r_state == ST_RESP) && BVALID;

`ifdef AXI_WR_ARB_BRESP_TMO_EN
    localparam logic [15:0] LP_TMO_LAST = 16'(BRESP_TMO - 1);

    logic [15:0] r_tmo;

    // Held at zero outside RESP so it starts from zero on every RESP entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= 16'd0;
        end else if (r_state != ST_RESP) begin
            r_tmo <= 16'd0;
        end else begin
            r_tmo <= r_tmo + 16'd1;
        end
    end

    // A response arriving in the timeout cycle takes precedence.
    assign w_resp_tmo = (r_state == ST_RESP) && !BVALID && (r_tmo == LP_TMO_LAST);
`else
    assign w_resp_tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= 4'b0000;
            r_wvalid <= 1'b0;
            r_bready <= 1'b0;
            r_count  <= 8'd0;
            r_last   <= 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant  <= 4'b0001 << w_winner_idx;
                        r_wvalid <= 1'b1;
                        r_count  <= 8'd0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // req is not consulted here: a started burst always runs to the end.
                    if (w_xfer) begin
                        r_count <= r_count + 8'd1;
                        if (w_last_beat) begin
                            r_wvalid <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (w_resp_ok || w_resp_tmo) begin
                        r_bready <= 1'b0;
                        r_grant  <= 4'b0000;
                        r_last   <= w_owner_idx;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign M_WVALID = r_wvalid;
    assign M_WLAST  = w_last_beat;
    assign BREADY   = r_bready;
    assign M_WDATA  = (r_state == ST_DATA) ? w_owner_data : 32'd0;
    assign beat_ack = w_xfer     ? r_grant : 4'b0000;
    assign done     = w_resp_ok  ? r_grant : 4'b0000;
    assign err      = w_resp_tmo ? r_grant : 4'b0000;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
module tb_axi_wr_arbiter;

    localparam int DATA_LEN  = 4;
    localparam int BRESP_TMO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [127:0] req_data = '0;
    logic         S_WREADY = 1'b0;
    logic         BVALID = 1'b0;
    logic [3:0]   grant;
    logic [3:0]   beat_ack;
    logic [3:0]   done;
    logic [3:0]   err;
    logic [31:0]  M_WDATA;
    logic         M_WVALID;
    logic         M_WLAST;
    logic         BREADY;

    always #5 clk = ~clk;

    axi_wr_arbiter #(
        .DATA_LEN  (DATA_LEN),
        .BRESP_TMO (BRESP_TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .beat_ack (beat_ack),
        .done     (done),
        .err      (err),
        .M_WDATA  (M_WDATA),
        .M_WVALID (M_WVALID),
        .M_WLAST  (M_WLAST),
        .S_WREADY (S_WREADY),
        .BVALID   (BVALID),
        .BREADY   (BREADY)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        wr;
        logic        bv;
        logic [3:0]  e_grant;
        logic        e_wv;
        logic        e_wl;
        logic [31:0] e_wd;
        logic [3:0]  e_back;
        logic [3:0]  e_done;
        logic        e_br;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] r, input logic [31:0] d0, input logic [31:0] d1,
                                input logic wr, input logic bv,
                                input logic [3:0] eg, input logic ewv, input logic ewl,
                                input logic [31:0] ewd, input logic [3:0] eba,
                                input logic [3:0] edn, input logic ebr);
        vec_t v;
        v.req = r; v.d0 = d0; v.d1 = d1; v.wr = wr; v.bv = bv;
        v.e_grant = eg; v.e_wv = ewv; v.e_wl = ewl; v.e_wd = ewd;
        v.e_back = eba; v.e_done = edn; v.e_br = ebr;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        S_WREADY = 1'b0;
        BVALID = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first;
        logic [3:0] errv;
        logic [3:0] dsum;

        // Cycle-by-cycle vectors: req, d0, d1, wready, bvalid ->
        // grant, wvalid, wlast, wdata, beat_ack, done, bready
        add(4'b0000, 32'h0,         32'h0,         1, 0, 4'b0000, 0, 0, 32'h0,         4'b0000, 4'b0000, 0);
        add(4'b0001, 32'hA000_0001, 32'h0,         1, 0, 4'b0000, 0, 0, 32'h0,         4'b0000, 4'b0000, 0);
        add(4'b0001, 32'hA000_0001, 32'h0,         1, 0, 4'b0001, 1, 0, 32'hA000_0001, 4'b0001, 4'b0000, 0);
        add(4'b0001, 32'hA000_0002, 32'h0,         1, 0, 4'b0001, 1, 0, 32'hA000_0002, 4'b0001, 4'b0000, 0);
        add(4'b0001, 32'hA000_0003, 32'h0,         1, 0, 4'b0001, 1, 0, 32'hA000_0003, 4'b0001, 4'b0000, 0);
        add(4'b0001, 32'hA000_0004, 32'h0,         1, 0, 4'b0001, 1, 1, 32'hA000_0004, 4'b0001, 4'b0000, 0);
        add(4'b0000, 32'hFFFF_FFFF, 32'h0,         1, 0, 4'b0001, 0, 0, 32'h0,         4'b0000, 4'b0000, 1);
        add(4'b0000, 32'h0,         32'h0,         1, 1, 4'b0001, 0, 0, 32'h0,         4'b0000, 4'b0001, 1);
        add(4'b0000, 32'h0,         32'h0,         1, 1, 4'b0000, 0, 0, 32'h0,         4'b0000, 4'b0000, 0);
        add(4'b0011, 32'h0,         32'hB000_0001, 0, 0, 4'b0000, 0, 0, 32'h0,         4'b0000, 4'b0000, 0);
        add(4'b0011, 32'hA000_0009, 32'hB000_0001, 1, 0, 4'b0010, 1, 0, 32'hB000_0001, 4'b0010, 4'b0000, 0);
        add(4'b0011, 32'hA000_0009, 32'hB000_0002, 0, 0, 4'b0010, 1, 0, 32'hB000_0002, 4'b0000, 4'b0000, 0);
        add(4'b0011, 32'hA000_0009, 32'hB000_0002, 0, 0, 4'b0010, 1, 0, 32'hB000_0002, 4'b0000, 4'b0000, 0);
        add(4'b0011, 32'hA000_0009, 32'hB000_0002, 1, 0, 4'b0010, 1, 0, 32'hB000_0002, 4'b0010, 4'b0000, 0);
        add(4'b0011, 32'hA000_0009, 32'hB000_0003, 1, 0, 4'b0010, 1, 0, 32'hB000_0003, 4'b0010, 4'b0000, 0);
        add(4'b0011, 32'hA000_0009, 32'hB000_0004, 0, 0, 4'b0010, 1, 1, 32'hB000_0004, 4'b0000, 4'b0000, 0);
        add(4'b0011, 32'hA000_0009, 32'hB000_0004, 1, 0, 4'b0010, 1, 1, 32'hB000_0004, 4'b0010, 4'b0000, 0);
        add(4'b0000, 32'h0,         32'h0,         1, 1, 4'b0010, 0, 0, 32'h0,         4'b0000, 4'b0010, 1);
        add(4'b0000, 32'h0,         32'h0,         1, 0, 4'b0000, 0, 0, 32'h0,         4'b0000, 4'b0000, 0);

        // Reset state while rst is held.
        #2;
        check("reset_outputs", {grant, M_WVALID, M_WLAST, M_WDATA, beat_ack, done, BREADY, err}, 64'd0);

        do_reset();

        foreach (vecs[i]) begin
            req      = vecs[i].req;
            req_data = {32'h3333_3333, 32'h2222_2222, vecs[i].d1, vecs[i].d0};
            S_WREADY = vecs[i].wr;
            BVALID   = vecs[i].bv;
            #1;
            check($sformatf("vec%0d", i),
                  {grant, M_WVALID, M_WLAST, M_WDATA, beat_ack, done, BREADY, err},
                  {vecs[i].e_grant, vecs[i].e_wv, vecs[i].e_wl, vecs[i].e_wd,
                   vecs[i].e_back, vecs[i].e_done, vecs[i].e_br, 4'b0000});
            step();
        end

        // Round-robin with all requesters active: 0,1,2,3,0,1,2,3 and one idle cycle between.
        do_reset();
        req = 4'b1111;
        S_WREADY = 1'b1;
        BVALID = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int cyc;
            int hi;
            cyc = 0;
            while (grant == 4'b0000 && cyc < 20) begin step(); cyc++; end
            check($sformatf("rr_grant%0d", k), grant, 4'b0001 << (k % 4));
            if (k > 0) check($sformatf("rr_gap%0d", k), cyc, 1);
            hi = 0;
            while (grant != 4'b0000 && hi < 20) begin step(); hi++; end
            check($sformatf("rr_len%0d", k), hi, 5);
        end

        // Mid-burst reset: complete one burst by requester 2, start another, reset at beat 2.
        do_reset();
        req = 4'b0100;
        S_WREADY = 1'b1;
        BVALID = 1'b1;
        n = 0;
        while (grant == 4'b0000 && n < 20) begin step(); n++; end
        n = 0;
        while (grant != 4'b0000 && n < 20) begin step(); n++; end
        check("rst_first_burst_end", n < 20, 1);
        BVALID = 1'b0;
        n = 0;
        while (grant == 4'b0000 && n < 20) begin step(); n++; end
        check("rst_owner", grant, 4'b0100);
        step();
        check("rst_beat2_ack", beat_ack, 4'b0100);
        rst = 1'b1;
        #1;
        check("rst_async_zero", {grant, M_WVALID, M_WLAST, M_WDATA, beat_ack, done, BREADY, err}, 64'd0);
        step();
        rst = 1'b0;
        req = 4'b1111;
        #1;
        check("rst_done_quiet", {done, err}, 8'd0);
        step();
        check("rst_next_grant", grant, 4'b0001);
        check("rst_done_quiet2", {done, err}, 8'd0);

        // Response timeout: BVALID withheld.
        do_reset();
        req = 4'b0001;
        S_WREADY = 1'b1;
        BVALID = 1'b0;
        n = 0;
        while (!BREADY && n < 20) begin step(); n++; end
        check("tmo_reach_resp", BREADY, 1'b1);
        req = 4'b0000;
        first = 0;
        errv = 4'b0000;
        dsum = 4'b0000;
        for (int c = 1; c <= 8; c++) begin
            if (err != 4'b0000 && first == 0) begin
                first = c;
                errv = err;
            end
            dsum = dsum | done;
            if (c < 8) step();
        end
`ifdef AXI_WR_ARB_BRESP_TMO_EN
        check("tmo_err_cycle", first, 8);
        check("tmo_err_owner", errv, 4'b0001);
        check("tmo_no_done", dsum, 4'b0000);
        step();
        check("tmo_back_idle", {grant, BREADY, err}, 9'd0);
`else
        check("tmo_no_err", first, 0);
        check("tmo_no_done", dsum, 4'b0000);
        repeat (20) begin
            step();
            if (err != 4'b0000) first = 99;
        end
        check("tmo_err_never", first, 0);
        check("tmo_stay_resp", {grant, BREADY}, {4'b0001, 1'b1});
        BVALID = 1'b1;
        #1;
        check("tmo_late_done", done, 4'b0001);
        step();
        BVALID = 1'b0;
        check("tmo_late_idle", {grant, BREADY}, 5'd0);
`endif

        // BVALID arriving in the 8th RESP cycle completes normally.
        req = 4'b0001;
        n = 0;
        while (!BREADY && n < 20) begin step(); n++; end
        check("bv8_reach_resp", BREADY, 1'b1);
        req = 4'b0000;
        repeat (7) step();
        BVALID = 1'b1;
        #1;
        check("bv8_done_wins", {done, err}, {4'b0001, 4'b0000});
        step();
        BVALID = 1'b0;
        check("bv8_idle", {grant, BREADY}, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
